// File: rtl/ex_operand_stage_pkg.sv
// Shared types for the ID/EX operand stage: widths, ALU op codes, forward select, ID/EX record.
package ex_operand_stage_pkg;

  localparam int XLEN      = 32;
  localparam int REG_AW    = 5;
  localparam int ALUCTRL_W = 4;

  typedef enum logic [ALUCTRL_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_PASS = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_MEM  = 2'd1,
    FWD_WB   = 2'd2
  } fwd_sel_e;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rs1_addr;
    logic [REG_AW-1:0] rs2_addr;
    logic [REG_AW-1:0] rd_addr;
    alu_op_e           alu_ctrl;
    logic              src1_pc;
    logic              src2_imm;
    logic              reg_write;
  } id_ex_t;

  // x0 is hardwired zero, so it never matches a producer.
  function automatic logic addr_hit(input logic en, input logic [REG_AW-1:0] rd,
                                    input logic [REG_AW-1:0] rs);
    return en && (rd == rs) && (rs != '0);
  endfunction

endpackage

// File: rtl/ex_operand_stage_if.sv
// Decode, forwarding and ALU-side signals of the operand stage; master = surroundings, slave = stage.
interface ex_operand_stage_if;
  import ex_operand_stage_pkg::*;

  logic                 id_valid;
  logic                 id_ready;
  logic [XLEN-1:0]      id_pc;
  logic [XLEN-1:0]      id_rs1_data;
  logic [XLEN-1:0]      id_rs2_data;
  logic [XLEN-1:0]      id_imm;
  logic [REG_AW-1:0]    id_rs1_addr;
  logic [REG_AW-1:0]    id_rs2_addr;
  logic [REG_AW-1:0]    id_rd_addr;
  logic [ALUCTRL_W-1:0] id_alu_ctrl;
  logic                 id_src1_pc;
  logic                 id_src2_imm;
  logic                 id_reg_write;

  logic                 mem_fwd_en;
  logic                 mem_is_load;
  logic [REG_AW-1:0]    mem_rd_addr;
  logic [XLEN-1:0]      mem_rd_data;
  logic                 wb_fwd_en;
  logic [REG_AW-1:0]    wb_rd_addr;
  logic [XLEN-1:0]      wb_rd_data;

  logic                 ex_valid;
  logic                 ex_ready;
  logic [XLEN-1:0]      alu_din1;
  logic [XLEN-1:0]      alu_din2;
  logic [ALUCTRL_W-1:0] alu_ctrl;
  logic [REG_AW-1:0]    ex_rd_addr;
  logic                 ex_reg_write;
  logic [XLEN-1:0]      ex_rs2_fwd;
  logic [XLEN-1:0]      ex_pc;

  modport master (
    output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1_addr, id_rs2_addr,
           id_rd_addr, id_alu_ctrl, id_src1_pc, id_src2_imm, id_reg_write,
           mem_fwd_en, mem_is_load, mem_rd_addr, mem_rd_data,
           wb_fwd_en, wb_rd_addr, wb_rd_data, ex_ready,
    input  id_ready, ex_valid, alu_din1, alu_din2, alu_ctrl, ex_rd_addr, ex_reg_write,
           ex_rs2_fwd, ex_pc
  );

  modport slave (
    input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1_addr, id_rs2_addr,
           id_rd_addr, id_alu_ctrl, id_src1_pc, id_src2_imm, id_reg_write,
           mem_fwd_en, mem_is_load, mem_rd_addr, mem_rd_data,
           wb_fwd_en, wb_rd_addr, wb_rd_data, ex_ready,
    output id_ready, ex_valid, alu_din1, alu_din2, alu_ctrl, ex_rd_addr, ex_reg_write,
           ex_rs2_fwd, ex_pc
  );

endinterface

// File: rtl/ex_operand_stage_fwd_mux.sv
// Per-source forwarding mux: MEM result beats WB result, x0 is never forwarded. Purely combinational.
module ex_fwd_mux
  import ex_operand_stage_pkg::*;
(
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [XLEN-1:0]   rs_data,
  input  logic              mem_fwd_en,
  input  logic [REG_AW-1:0] mem_rd_addr,
  input  logic [XLEN-1:0]   mem_rd_data,
  input  logic              wb_fwd_en,
  input  logic [REG_AW-1:0] wb_rd_addr,
  input  logic [XLEN-1:0]   wb_rd_data,
  output logic [XLEN-1:0]   fwd_data,
  output fwd_sel_e          fwd_sel
);

  always_comb begin
    fwd_sel  = FWD_NONE;
    fwd_data = rs_data;
    if (addr_hit(mem_fwd_en, mem_rd_addr, rs_addr)) begin
      fwd_sel  = FWD_MEM;
      fwd_data = mem_rd_data;
    end else if (addr_hit(wb_fwd_en, wb_rd_addr, rs_addr)) begin
      fwd_sel  = FWD_WB;
      fwd_data = wb_rd_data;
    end
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX register with MEM/WB forwarding and load-use stall; operands valid one cycle after capture.
// Single entry: id_ready only while empty or draining this cycle; held operands track forwarding while stalled.
module ex_operand_stage
  import ex_operand_stage_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  ex_operand_stage_if.slave   bus
);

  logic            occ;
  id_ex_t          q;
  logic            hazard;
  logic            ex_valid_int;
  logic            ex_fire;
  logic            capture;
  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;
  fwd_sel_e        rs1_sel;
  fwd_sel_e        rs2_sel;
  logic [XLEN-1:0] cap_rs1;
  logic [XLEN-1:0] cap_rs2;

  ex_fwd_mux u_fwd_rs1 (
    .rs_addr     (q.rs1_addr),
    .rs_data     (q.rs1_data),
    .mem_fwd_en  (bus.mem_fwd_en),
    .mem_rd_addr (bus.mem_rd_addr),
    .mem_rd_data (bus.mem_rd_data),
    .wb_fwd_en   (bus.wb_fwd_en),
    .wb_rd_addr  (bus.wb_rd_addr),
    .wb_rd_data  (bus.wb_rd_data),
    .fwd_data    (rs1_fwd),
    .fwd_sel     (rs1_sel)
  );

  ex_fwd_mux u_fwd_rs2 (
    .rs_addr     (q.rs2_addr),
    .rs_data     (q.rs2_data),
    .mem_fwd_en  (bus.mem_fwd_en),
    .mem_rd_addr (bus.mem_rd_addr),
    .mem_rd_data (bus.mem_rd_data),
    .wb_fwd_en   (bus.wb_fwd_en),
    .wb_rd_addr  (bus.wb_rd_addr),
    .wb_rd_data  (bus.wb_rd_data),
    .fwd_data    (rs2_fwd),
    .fwd_sel     (rs2_sel)
  );

  // A MEM hit on a load means the value is not produced yet; rs2 always counts (store data).
  assign hazard = occ & bus.mem_is_load &
                  (((rs1_sel == FWD_MEM) & ~q.src1_pc) | (rs2_sel == FWD_MEM));

  assign ex_valid_int = occ & ~hazard;
  assign ex_fire      = ex_valid_int & bus.ex_ready;
  assign bus.id_ready = ~occ | ex_fire;
  assign capture      = bus.id_valid & (~occ | ex_fire) & ~flush;

  // Register-file data may be one write behind; catch the WB write landing this cycle.
  assign cap_rs1 = addr_hit(bus.wb_fwd_en, bus.wb_rd_addr, bus.id_rs1_addr) ?
                   bus.wb_rd_data : bus.id_rs1_data;
  assign cap_rs2 = addr_hit(bus.wb_fwd_en, bus.wb_rd_addr, bus.id_rs2_addr) ?
                   bus.wb_rd_data : bus.id_rs2_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ <= 1'b0;
      q   <= '0;
    end else if (flush) begin
      occ <= 1'b0;
    end else if (capture) begin
      occ         <= 1'b1;
      q.pc        <= bus.id_pc;
      q.rs1_data  <= cap_rs1;
      q.rs2_data  <= cap_rs2;
      q.imm       <= bus.id_imm;
      q.rs1_addr  <= bus.id_rs1_addr;
      q.rs2_addr  <= bus.id_rs2_addr;
      q.rd_addr   <= bus.id_rd_addr;
      q.alu_ctrl  <= alu_op_e'(bus.id_alu_ctrl);
      q.src1_pc   <= bus.id_src1_pc;
      q.src2_imm  <= bus.id_src2_imm;
      q.reg_write <= bus.id_reg_write;
    end else if (ex_fire) begin
      occ <= 1'b0;
    end else if (occ) begin
      // Latch the forwarded values so they outlive a producer that retires during the stall.
      q.rs1_data <= rs1_fwd;
      q.rs2_data <= rs2_fwd;
    end
  end

  assign bus.ex_valid     = ex_valid_int;
  assign bus.alu_din1     = q.src1_pc  ? q.pc  : rs1_fwd;
  assign bus.alu_din2     = q.src2_imm ? q.imm : rs2_fwd;
  assign bus.alu_ctrl     = q.alu_ctrl;
  assign bus.ex_rd_addr   = q.rd_addr;
  assign bus.ex_reg_write = occ & q.reg_write;
  assign bus.ex_rs2_fwd   = rs2_fwd;
  assign bus.ex_pc        = q.pc;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed scenarios followed by a randomized run against a transaction-level reference model.
module tb_ex_operand_stage;
  import ex_operand_stage_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  ex_operand_stage_if bus();

  ex_operand_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clr_fwd();
    bus.mem_fwd_en  = 1'b0;
    bus.mem_is_load = 1'b0;
    bus.mem_rd_addr = '0;
    bus.mem_rd_data = '0;
    bus.wb_fwd_en   = 1'b0;
    bus.wb_rd_addr  = '0;
    bus.wb_rd_data  = '0;
  endtask

  task automatic present(input logic [31:0] pc, input logic [4:0] rs1a, input logic [31:0] rs1d,
                         input logic [4:0] rs2a, input logic [31:0] rs2d, input logic [31:0] imm,
                         input logic [4:0] rd, input alu_op_e op, input logic s1pc,
                         input logic s2imm, input logic rw);
    bus.id_valid     = 1'b1;
    bus.id_pc        = pc;
    bus.id_rs1_addr  = rs1a;
    bus.id_rs1_data  = rs1d;
    bus.id_rs2_addr  = rs2a;
    bus.id_rs2_data  = rs2d;
    bus.id_imm       = imm;
    bus.id_rd_addr   = rd;
    bus.id_alu_ctrl  = op;
    bus.id_src1_pc   = s1pc;
    bus.id_src2_imm  = s2imm;
    bus.id_reg_write = rw;
  endtask

  // Reference model: the held instruction as the decoder handed it over plus an occupancy flag.
  typedef struct {
    logic [31:0] pc, rs1v, rs2v, imm;
    logic [4:0]  rs1a, rs2a, rd;
    logic [3:0]  op;
    logic        s1pc, s2imm, rw;
  } ins_t;

  ins_t m;
  logic m_occ;

  // Newest available producer value for a source register: MEM, then WB, else what we hold.
  function automatic logic [31:0] newest(input logic [4:0] a, input logic [31:0] held,
                                         input logic use_mem);
    if (a == 0) return held;
    if (use_mem && bus.mem_fwd_en && bus.mem_rd_addr == a) return bus.mem_rd_data;
    if (bus.wb_fwd_en && bus.wb_rd_addr == a) return bus.wb_rd_data;
    return held;
  endfunction

  initial begin
    clr_fwd();
    bus.id_valid = 1'b0;
    bus.ex_ready = 1'b0;
    present(0, 0, 0, 0, 0, 0, 0, ALU_ADD, 0, 0, 0);
    bus.id_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_ex_valid", {31'b0, bus.ex_valid}, 0);
    chk("rst_id_ready", {31'b0, bus.id_ready}, 1);
    chk("rst_din1", bus.alu_din1, 0);
    chk("rst_din2", bus.alu_din2, 0);
    chk("rst_alu_ctrl", {28'b0, bus.alu_ctrl}, 0);
    chk("rst_reg_write", {31'b0, bus.ex_reg_write}, 0);

    // Plain capture, no forwarding.
    bus.ex_ready = 1'b1;
    present(32'h100, 5'd1, 32'd5, 5'd2, 32'd7, 0, 5'd3, ALU_ADD, 0, 0, 1);
    #1 chk("cap_id_ready", {31'b0, bus.id_ready}, 1);
    @(negedge clk);
    bus.id_valid = 1'b0;
    #1;
    chk("cap_ex_valid", {31'b0, bus.ex_valid}, 1);
    chk("cap_din1", bus.alu_din1, 5);
    chk("cap_din2", bus.alu_din2, 7);
    chk("cap_alu_ctrl", {28'b0, bus.alu_ctrl}, {28'b0, ALU_ADD});
    chk("cap_rd", {27'b0, bus.ex_rd_addr}, 3);
    chk("cap_pc", bus.ex_pc, 32'h100);
    @(negedge clk);
    #1 chk("cap_drained", {31'b0, bus.ex_valid}, 0);

    // Forward priority.
    bus.ex_ready = 1'b0;
    present(32'h200, 5'd3, 32'h33, 5'd0, 0, 0, 5'd6, ALU_OR, 0, 0, 1);
    @(negedge clk);
    bus.id_valid = 1'b0;
    bus.mem_fwd_en = 1'b1; bus.mem_rd_addr = 5'd3; bus.mem_rd_data = 32'h10;
    bus.wb_fwd_en  = 1'b1; bus.wb_rd_addr  = 5'd3; bus.wb_rd_data  = 32'h20;
    #1 chk("fwd_mem_over_wb", bus.alu_din1, 32'h10);
    @(negedge clk);
    bus.mem_fwd_en = 1'b0;
    #1 chk("fwd_wb_only", bus.alu_din1, 32'h20);
    @(negedge clk);
    clr_fwd();
    bus.ex_ready = 1'b1;
    #1 chk("fwd_wb_kept", bus.alu_din1, 32'h20);
    @(negedge clk);
    bus.ex_ready = 1'b0;
    present(32'h240, 5'd0, 32'h77, 5'd0, 0, 0, 5'd7, ALU_ADD, 0, 0, 1);
    @(negedge clk);
    bus.id_valid = 1'b0;
    bus.mem_fwd_en = 1'b1; bus.mem_rd_addr = 5'd0; bus.mem_rd_data = 32'h9;
    bus.wb_fwd_en  = 1'b1; bus.wb_rd_addr  = 5'd0; bus.wb_rd_data  = 32'h9;
    #1 chk("fwd_x0_stored", bus.alu_din1, 32'h77);
    clr_fwd();
    bus.ex_ready = 1'b1;
    @(negedge clk);

    // Load-use stall.
    present(32'h300, 5'd0, 0, 5'd4, 32'h1111, 0, 5'd8, ALU_SUB, 0, 0, 1);
    @(negedge clk);
    present(32'h340, 5'd1, 1, 5'd2, 2, 0, 5'd9, ALU_ADD, 0, 0, 1);
    bus.mem_is_load = 1'b1; bus.mem_fwd_en = 1'b1;
    bus.mem_rd_addr = 5'd4; bus.mem_rd_data = 32'hDEAD;
    #1;
    chk("lu_ex_valid", {31'b0, bus.ex_valid}, 0);
    chk("lu_id_ready", {31'b0, bus.id_ready}, 0);
    @(negedge clk);
    bus.id_valid = 1'b0;
    clr_fwd();
    bus.wb_fwd_en = 1'b1; bus.wb_rd_addr = 5'd4; bus.wb_rd_data = 32'hABCD;
    #1;
    chk("lu_resume_valid", {31'b0, bus.ex_valid}, 1);
    chk("lu_resume_din2", bus.alu_din2, 32'hABCD);
    chk("lu_resume_pc", bus.ex_pc, 32'h300);
    @(negedge clk);
    clr_fwd();
    #1 chk("lu_drained", {31'b0, bus.ex_valid}, 0);

    // Hold refresh across a downstream stall.
    bus.ex_ready = 1'b0;
    present(32'h500, 5'd5, 32'h5, 5'd0, 0, 0, 5'd9, ALU_XOR, 0, 0, 1);
    @(negedge clk);
    bus.id_valid = 1'b0;
    bus.wb_fwd_en = 1'b1; bus.wb_rd_addr = 5'd5; bus.wb_rd_data = 32'h55;
    #1 chk("hold_c1", bus.alu_din1, 32'h55);
    @(negedge clk);
    clr_fwd();
    #1 chk("hold_c2", bus.alu_din1, 32'h55);
    @(negedge clk);
    #1 chk("hold_c3", bus.alu_din1, 32'h55);
    @(negedge clk);
    bus.ex_ready = 1'b1;
    #1;
    chk("hold_fire_valid", {31'b0, bus.ex_valid}, 1);
    chk("hold_fire_din1", bus.alu_din1, 32'h55);
    @(negedge clk);

    // Flush drops both held and incoming instruction.
    bus.ex_ready = 1'b0;
    present(32'h600, 5'd1, 1, 5'd2, 2, 0, 5'd10, ALU_AND, 0, 0, 1);
    @(negedge clk);
    present(32'h700, 5'd1, 1, 5'd2, 2, 0, 5'd11, ALU_AND, 0, 0, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    bus.id_valid = 1'b0;
    #1;
    chk("flush_id_ready", {31'b0, bus.id_ready}, 1);
    chk("flush_reg_write", {31'b0, bus.ex_reg_write}, 0);
    for (int i = 0; i < 3; i++) begin
      chk("flush_ex_valid", {31'b0, bus.ex_valid}, 0);
      chk("flush_not_seen", {31'b0, bus.ex_pc == 32'h700}, 0);
      @(negedge clk);
      #1;
    end

    // Asynchronous reset while holding.
    @(negedge clk);
    present(32'h800, 5'd1, 32'hAAAA, 5'd2, 32'hBBBB, 0, 5'd12, ALU_SLT, 0, 0, 1);
    @(negedge clk);
    bus.id_valid = 1'b0;
    #1 chk("arst_pre_valid", {31'b0, bus.ex_valid}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ex_valid", {31'b0, bus.ex_valid}, 0);
    chk("arst_din1", bus.alu_din1, 0);
    chk("arst_din2", bus.alu_din2, 0);
    chk("arst_id_ready", {31'b0, bus.id_ready}, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic against the reference model.
    m_occ = 1'b0;
    m = '{default: '0};
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic [31:0] r1, r2, e1, e2;
      logic        hz, ev, er, fire, take;
      @(negedge clk);
      flush            = ($urandom % 12) == 0;
      bus.id_valid     = $urandom % 2;
      bus.id_pc        = $urandom;
      bus.id_rs1_addr  = 5'($urandom % 4);
      bus.id_rs2_addr  = 5'($urandom % 4);
      bus.id_rs1_data  = $urandom;
      bus.id_rs2_data  = $urandom;
      bus.id_imm       = $urandom;
      bus.id_rd_addr   = 5'($urandom % 32);
      bus.id_alu_ctrl  = 4'($urandom_range(0, 10));
      bus.id_src1_pc   = ($urandom % 4) == 0;
      bus.id_src2_imm  = $urandom % 2;
      bus.id_reg_write = $urandom % 2;
      bus.mem_fwd_en   = $urandom % 2;
      bus.mem_is_load  = ($urandom % 3) == 0;
      bus.mem_rd_addr  = 5'($urandom % 4);
      bus.mem_rd_data  = $urandom;
      bus.wb_fwd_en    = $urandom % 2;
      bus.wb_rd_addr   = 5'($urandom % 4);
      bus.wb_rd_data   = $urandom;
      bus.ex_ready     = ($urandom % 4) != 0;
      #1;
      r1 = newest(m.rs1a, m.rs1v, 1'b1);
      r2 = newest(m.rs2a, m.rs2v, 1'b1);
      hz = m_occ && bus.mem_is_load && bus.mem_fwd_en && bus.mem_rd_addr != 0 &&
           ((!m.s1pc && m.rs1a == bus.mem_rd_addr) || m.rs2a == bus.mem_rd_addr);
      ev = m_occ && !hz;
      er = !m_occ || (ev && bus.ex_ready);
      chk("rnd_id_ready", {31'b0, bus.id_ready}, {31'b0, er});
      chk("rnd_ex_valid", {31'b0, bus.ex_valid}, {31'b0, ev});
      if (ev) begin
        e1 = m.s1pc ? m.pc : r1;
        e2 = m.s2imm ? m.imm : r2;
        chk("rnd_din1", bus.alu_din1, e1);
        chk("rnd_din2", bus.alu_din2, e2);
        chk("rnd_rs2_fwd", bus.ex_rs2_fwd, r2);
        chk("rnd_alu_ctrl", {28'b0, bus.alu_ctrl}, {28'b0, m.op});
        chk("rnd_pc", bus.ex_pc, m.pc);
        chk("rnd_rd", {27'b0, bus.ex_rd_addr}, {27'b0, m.rd});
        chk("rnd_reg_write", {31'b0, bus.ex_reg_write}, {31'b0, m.rw});
      end
      fire = ev && bus.ex_ready;
      take = bus.id_valid && er && !flush;
      if (flush) begin
        m_occ = 1'b0;
      end else if (take) begin
        m_occ  = 1'b1;
        m.pc   = bus.id_pc;
        m.rs1a = bus.id_rs1_addr;
        m.rs2a = bus.id_rs2_addr;
        m.rs1v = newest(bus.id_rs1_addr, bus.id_rs1_data, 1'b0);
        m.rs2v = newest(bus.id_rs2_addr, bus.id_rs2_data, 1'b0);
        m.imm  = bus.id_imm;
        m.rd   = bus.id_rd_addr;
        m.op   = bus.id_alu_ctrl;
        m.s1pc = bus.id_src1_pc;
        m.s2imm = bus.id_src2_imm;
        m.rw   = bus.id_reg_write;
      end else if (fire) begin
        m_occ = 1'b0;
      end else if (m_occ) begin
        m.rs1v = r1;
        m.rs2v = r2;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
